// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and its decode side.
package instr_encoder_pkg;

    // Request class codes carried on req_class
    typedef enum logic [1:0] {
        CLS_LOAD   = 2'b00,
        CLS_STORE  = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_BRANCH = 2'b11
    } reqClass_e;

    // R-type ALU selector codes carried on req_alu_sel
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } aluSel_e;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SUB = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLT = 3'b010;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: request fields -> 32-bit instruction word plus illegal flag.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  cls,
    input  logic [2:0]  aluSel,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [2:0] f3;
    logic [6:0] f7;

    // Field packing per class; unused operands never reach the word
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        f3      = F3_ADD;
        f7      = F7_BASE;
        case (cls)
            CLS_LOAD: begin
                // 12-bit offset: bit 12 must be a pure sign extension
                illegal = imm[12] != imm[11];
                word    = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            end
            CLS_STORE: begin
                illegal = imm[12] != imm[11];
                word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            end
            CLS_RTYPE: begin
                case (aluSel)
                    ALU_ADD: begin f3 = F3_ADD; f7 = F7_BASE; end
                    ALU_SUB: begin f3 = F3_SUB; f7 = F7_SUB;  end
                    ALU_AND: begin f3 = F3_AND; f7 = F7_BASE; end
                    ALU_OR:  begin f3 = F3_OR;  f7 = F7_BASE; end
                    ALU_SLT: begin f3 = F3_SLT; f7 = F7_BASE; end
                    default: illegal = 1'b1;
                endcase
                word = {f7, rs2, rs1, f3, rd, OP_RTYPE};
            end
            default: begin
                // Branch offsets are halfword-aligned
                illegal = imm[0];
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction image builder: accepts encode requests and streams packed words into imem.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_class,
    input  logic [2:0]        req_alu_sel,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FULL = 2'b10
    } state_e;

    state_e            state, stateNxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       packWord;
    logic              packIllegal;
    logic              accept, acceptLegal, lastSlot;

    instr_pack uPack (
        .cls     (req_class),
        .aluSel  (req_alu_sel),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (packWord),
        .illegal (packIllegal)
    );

    assign req_ready   = state == ST_RUN;
    assign full        = state == ST_FULL;
    assign count       = cnt;
    assign accept      = req_valid && req_ready;
    assign acceptLegal = accept && !packIllegal;
    assign lastSlot    = ptr == {ADDR_W{1'b1}};

    // Next-state: filling the last slot wins over a coincident finish
    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE, ST_FULL: if (start) stateNxt = ST_RUN;
            ST_RUN: begin
                if (acceptLegal && lastSlot) stateNxt = ST_FULL;
                else if (finish)             stateNxt = ST_IDLE;
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNxt;
    end

    // Write pointer and word count; pointer parks on the last slot once full
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (start && state != ST_RUN) begin
            ptr <= '0;
            cnt <= '0;
        end else if (acceptLegal) begin
            cnt <= cnt + 1'b1;
            if (!lastSlot) ptr <= ptr + 1'b1;
        end
    end

    // Registered write port and error pulse; idle cycles drive zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            err_illegal <= 1'b0;
        end else begin
            imem_we     <= acceptLegal;
            imem_addr   <= acceptLegal ? ptr : '0;
            imem_wdata  <= acceptLegal ? packWord : '0;
            err_illegal <= accept && packIllegal;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default-width instance plus a 4-word instance for fill behaviour.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance (ADDR_W=6)
    logic        start, finish, reqValid, reqReady;
    logic [1:0]  reqClass;
    logic [2:0]  reqAluSel;
    logic [4:0]  reqRd, reqRs1, reqRs2;
    logic [12:0] reqImm;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [6:0]  cnt;
    logic        full, err;

    // Small instance (ADDR_W=2)
    logic        sStart, sFinish, sValid, sReady;
    logic [1:0]  sClass;
    logic [2:0]  sAluSel;
    logic [4:0]  sRd, sRs1, sRs2;
    logic [12:0] sImm;
    logic        sWe;
    logic [1:0]  sAddr;
    logic [31:0] sWdata;
    logic [2:0]  sCnt;
    logic        sFull, sErr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .req_valid(reqValid), .req_ready(reqReady), .req_class(reqClass),
        .req_alu_sel(reqAluSel), .req_rd(reqRd), .req_rs1(reqRs1), .req_rs2(reqRs2),
        .req_imm(reqImm), .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
        .count(cnt), .full(full), .err_illegal(err)
    );

    instr_encoder #(.ADDR_W(2)) dutSmall (
        .clk(clk), .rst(rst), .start(sStart), .finish(sFinish),
        .req_valid(sValid), .req_ready(sReady), .req_class(sClass),
        .req_alu_sel(sAluSel), .req_rd(sRd), .req_rs1(sRs1), .req_rs2(sRs2),
        .req_imm(sImm), .imem_we(sWe), .imem_addr(sAddr), .imem_wdata(sWdata),
        .count(sCnt), .full(sFull), .err_illegal(sErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] c, input logic [2:0] a, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] i);
        reqValid = 1'b1; reqClass = c; reqAluSel = a;
        reqRd = d; reqRs1 = s1; reqRs2 = s2; reqImm = i;
    endtask

    initial begin
        rst = 1'b1; start = 0; finish = 0; reqValid = 0; reqClass = 0; reqAluSel = 0;
        reqRd = 0; reqRs1 = 0; reqRs2 = 0; reqImm = 0;
        sStart = 0; sFinish = 0; sValid = 0; sClass = 0; sAluSel = 0;
        sRd = 0; sRs1 = 0; sRs2 = 0; sImm = 0;
        #1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_we", we, 0);      chk("rst_addr", addr, 0);  chk("rst_wdata", wdata, 0);
        chk("rst_count", cnt, 0);  chk("rst_full", full, 0);  chk("rst_err", err, 0);
        chk("rst_ready", reqReady, 0);

        // start -> RUN
        start = 1'b1; tick(); start = 1'b0;
        chk("run_ready", reqReady, 1);

        // LOAD rd=5 rs1=2 imm=8 (rs2 ignored)
        req(2'b00, 3'b000, 5'd5, 5'd2, 5'd7, 13'd8); tick();
        chk("ld_we", we, 1); chk("ld_addr", addr, 0); chk("ld_wdata", wdata, 32'h00812283);
        chk("ld_count", cnt, 1);

        // Back-to-back STORE, RTYPE sub, BRANCH -4
        req(2'b01, 3'b000, 5'd9, 5'd2, 5'd5, 13'd12); tick();
        chk("st_we", we, 1); chk("st_addr", addr, 1); chk("st_wdata", wdata, 32'h00512623);
        req(2'b10, 3'b001, 5'd3, 5'd1, 5'd2, 13'h1ABC); tick();
        chk("sub_we", we, 1); chk("sub_addr", addr, 2); chk("sub_wdata", wdata, 32'h402081B3);
        req(2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FFC); tick();
        chk("beq_we", we, 1); chk("beq_addr", addr, 3); chk("beq_wdata", wdata, 32'hFE208EE3);
        chk("beq_count", cnt, 4);
        reqValid = 1'b0; tick();
        chk("idle_we", we, 0); chk("idle_addr", addr, 0); chk("idle_wdata", wdata, 0);

        // Illegal requests: odd branch offset, alu_sel 101, out-of-range load offset
        req(2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'd3); tick();
        chk("ill_br_err", err, 1); chk("ill_br_we", we, 0);
        req(2'b10, 3'b101, 5'd3, 5'd1, 5'd2, 13'd0); tick();
        chk("ill_alu_err", err, 1); chk("ill_alu_we", we, 0);
        req(2'b00, 3'b000, 5'd3, 5'd1, 5'd0, 13'h0800); tick();
        chk("ill_ld_err", err, 1); chk("ill_ld_wdata", wdata, 0);
        reqValid = 1'b0; tick();
        chk("ill_err_clr", err, 0); chk("ill_count", cnt, 4);

        // RTYPE or, then rst coincident with a handshake drops the write
        req(2'b10, 3'b011, 5'd4, 5'd5, 5'd6, 13'd0); tick();
        chk("or_wdata", wdata, 32'h0062E233); chk("or_addr", addr, 4);
        rst = 1'b1; tick(); rst = 1'b0; reqValid = 1'b0;
        chk("mrst_we", we, 0); chk("mrst_wdata", wdata, 0); chk("mrst_count", cnt, 0);
        chk("mrst_ready", reqReady, 0);

        // finish with simultaneous handshake: write completes, then IDLE
        start = 1'b1; tick(); start = 1'b0;
        req(2'b00, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8); finish = 1'b1; tick();
        reqValid = 1'b0; finish = 1'b0;
        chk("fin_we", we, 1); chk("fin_wdata", wdata, 32'h00812283);
        chk("fin_ready", reqReady, 0); chk("fin_count", cnt, 1);

        // finish in IDLE ignored; start+finish together: start wins
        finish = 1'b1; tick();
        chk("fin_idle_ready", reqReady, 0);
        start = 1'b1; tick(); start = 1'b0; finish = 1'b0;
        chk("sf_ready", reqReady, 1); chk("sf_count", cnt, 0);

        // Small image fills after 4 words
        sStart = 1'b1; tick(); sStart = 1'b0;
        sValid = 1'b1; sClass = 2'b10; sAluSel = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            sRd = 5'(i); tick();
        end
        chk("fill_we", sWe, 1); chk("fill_addr", sAddr, 3); chk("fill_wdata", sWdata, 32'h00000233);
        chk("fill_full", sFull, 1); chk("fill_ready", sReady, 0); chk("fill_count", sCnt, 4);
        tick();
        chk("over_we", sWe, 0); chk("over_count", sCnt, 4);
        sValid = 1'b0; sStart = 1'b1; tick(); sStart = 1'b0;
        chk("restart_ready", sReady, 1); chk("restart_count", sCnt, 0); chk("restart_full", sFull, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter ADDR_W, default 6, SHALL set the instruction-memory address width (depth 2^ADDR_W words).
REQ-003 Port list (name  direction  width  meaning):
 clk  in  1  clock, rising edge
 rst  in  1  synchronous active-high reset
 start  in  1  pulse; clear write pointer, enter RUN
 finish  in  1  pulse; leave RUN, enter IDLE
 req_valid  in  1  encode request present
 req_ready  out  1  block accepts request this cycle
 req_class  in  2  00 LOAD(lw), 01 STORE(sw), 10 RTYPE, 11 BRANCH(beq)
 req_alu_sel  in  3  RTYPE op: 000 add, 001 sub, 010 and, 011 or, 100 slt
 req_rd, req_rs1, req_rs2  in  5 each  register indices
 req_imm  in  13  signed immediate/offset
 imem_we  out  1  instruction-memory write strobe
 imem_addr  out  ADDR_W  word address of write
 imem_wdata  out  32  encoded instruction
 count  out  ADDR_W+1  words written since last start
 full  out  1  image full
 err_illegal  out  1  one-cycle pulse on rejected request

Function
REQ-004 FSM states IDLE, RUN, FULL; reset state IDLE.
REQ-005 start SHALL be honoured in IDLE or FULL only (ignored in RUN): next state RUN, pointer and count to 0.
REQ-006 req_ready SHALL be combinational: high only when state==RUN.
REQ-007 Handshake at req_valid&&req_ready in cycle N; legal request -> imem_we=1 in cycle N+1 with imem_addr=pointer, imem_wdata=encoding; pointer and count +1 at the same edge.
REQ-008 imem_we SHALL be high for exactly one cycle per accepted legal request; back-to-back requests every cycle SHALL be supported (throughput 1/cycle).
REQ-009 Encodings: LOAD = imm[11:0],rs1,010,rd,0000011; STORE = imm[11:5],rs2,rs1,010,imm[4:0],0100011; RTYPE = funct7,rs2,rs1,funct3,rd,0110011 (add 0000000/000, sub 0100000/000, and 0000000/111, or 0000000/110, slt 0000000/010); BRANCH = imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011.
REQ-010 Illegal: LOAD/STORE with imm[12]!=imm[11]; BRANCH with imm[0]=1; RTYPE with alu_sel>100. An illegal request SHALL still be consumed, SHALL produce no write, SHALL pulse err_illegal in cycle N+1, and SHALL NOT advance pointer or count.
REQ-011 Unused operand fields (rs2 for LOAD, rd for STORE/BRANCH, imm for RTYPE) SHALL be ignored.
REQ-012 After the write to address 2^ADDR_W-1: state FULL, full=1, req_ready=0; count=2^ADDR_W; pointer holds.
REQ-013 finish in RUN -> IDLE; a handshake in the same cycle SHALL be accepted and its write completed in N+1.
REQ-014 finish in IDLE/FULL SHALL be ignored; start and finish together in IDLE/FULL: start wins.
REQ-015 imem_wdata and imem_addr SHALL be 0 whenever imem_we=0.

Reset
REQ-016 rst SHALL force at the next edge: state IDLE, pointer 0, count 0, full 0, imem_we 0, imem_addr 0, imem_wdata 0, err_illegal 0, req_ready 0.
REQ-017 rst mid-operation SHALL drop any pending write; rst has priority over start, finish, and handshake.

Structure
REQ-018 Opcode constants (0000011, 0100011, 0110011, 1100011), req_class codes, alu_sel codes and funct3/funct7 values SHALL live in a shared package, the same package the decode side uses.
REQ-019 The encoder SHALL be a combinational sub-module instr_pack (request fields -> 32-bit word + illegal flag); the FSM, pointer, and output register SHALL sit in instr_encoder.

Verification
REQ-020 start, then LOAD rd=5 rs1=2 imm=8 -> next cycle imem_we=1, addr=0, wdata=0x00812283; count=1.
REQ-021 Back-to-back STORE rs2=5 rs1=2 imm=12, RTYPE sub rd=3 rs1=1 rs2=2, BRANCH rs1=1 rs2=2 imm=-4 -> consecutive writes 0x00512623 @1, 0x402081B3 @2, 0xFE208EE3 @3.
REQ-022 BRANCH imm=3, then RTYPE alu_sel=101 -> two err_illegal pulses, no imem_we, count unchanged.
REQ-023 ADDR_W=2: 4 legal requests -> full=1, req_ready=0, count=4; 5th req_valid held -> no write; start -> RUN, count=0.
REQ-024 rst asserted in the cycle after a handshake -> no imem_we, all outputs 0; finish with simultaneous handshake -> write occurs, state IDLE, req_ready=0.
